// File: rtl/regbank_pkg.sv
// Shared constants, state encoding and decode helpers for the register-bank controller.
package regbank_pkg;

  localparam int unsigned MODE_W = 5;
  localparam int unsigned LREG_W = 4;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KIND_W = 3;

  localparam logic [MODE_W-1:0] MODE_USR = 5'b10000;
  localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
  localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
  localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;
  localparam logic [MODE_W-1:0] MODE_ABT = 5'b10111;
  localparam logic [MODE_W-1:0] MODE_UND = 5'b11011;
  localparam logic [MODE_W-1:0] MODE_SYS = 5'b11111;

  localparam logic [KIND_W-1:0] EXC_UND  = 3'd0;
  localparam logic [KIND_W-1:0] EXC_SWI  = 3'd1;
  localparam logic [KIND_W-1:0] EXC_PABT = 3'd2;
  localparam logic [KIND_W-1:0] EXC_DABT = 3'd3;
  localparam logic [KIND_W-1:0] EXC_IRQ  = 3'd4;
  localparam logic [KIND_W-1:0] EXC_FIQ  = 3'd5;

  localparam logic [DATA_W-1:0] VEC_UND  = 32'h0000_0004;
  localparam logic [DATA_W-1:0] VEC_SWI  = 32'h0000_0008;
  localparam logic [DATA_W-1:0] VEC_PABT = 32'h0000_000C;
  localparam logic [DATA_W-1:0] VEC_DABT = 32'h0000_0010;
  localparam logic [DATA_W-1:0] VEC_IRQ  = 32'h0000_0018;
  localparam logic [DATA_W-1:0] VEC_FIQ  = 32'h0000_001C;

  localparam logic [DATA_W-1:0] CPSR_CTRL_MASK = 32'h0000_00FF;

  // Physical bank layout: first index of each banked group, then PC/CPSR/SPSRs.
  localparam logic [IDX_W-1:0] IDX_FIQ_R8    = 6'd16;
  localparam logic [IDX_W-1:0] IDX_SVC_R13   = 6'd23;
  localparam logic [IDX_W-1:0] IDX_ABT_R13   = 6'd25;
  localparam logic [IDX_W-1:0] IDX_IRQ_R13   = 6'd27;
  localparam logic [IDX_W-1:0] IDX_UND_R13   = 6'd29;
  localparam logic [IDX_W-1:0] IDX_PC        = 6'd15;
  localparam logic [IDX_W-1:0] IDX_CPSR      = 6'd31;
  localparam logic [IDX_W-1:0] IDX_SPSR_FIQ  = 6'd32;
  localparam logic [IDX_W-1:0] IDX_SPSR_SVC  = 6'd33;
  localparam logic [IDX_W-1:0] IDX_SPSR_ABT  = 6'd34;
  localparam logic [IDX_W-1:0] IDX_SPSR_IRQ  = 6'd35;
  localparam logic [IDX_W-1:0] IDX_SPSR_UND  = 6'd36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CPSR,
    ST_WR_SPSR,
    ST_WR_LR,
    ST_WR_CPSR,
    ST_WR_PC
  } state_e;

  function automatic logic [IDX_W-1:0] spsr_idx(input logic [MODE_W-1:0] mode);
    case (mode)
      MODE_FIQ: spsr_idx = IDX_SPSR_FIQ;
      MODE_SVC: spsr_idx = IDX_SPSR_SVC;
      MODE_ABT: spsr_idx = IDX_SPSR_ABT;
      MODE_IRQ: spsr_idx = IDX_SPSR_IRQ;
      default:  spsr_idx = IDX_SPSR_UND;
    endcase
  endfunction

  // Codes 6 and 7 fall through to UND.
  function automatic logic [MODE_W-1:0] exc_mode(input logic [KIND_W-1:0] kind);
    case (kind)
      EXC_SWI:           exc_mode = MODE_SVC;
      EXC_PABT, EXC_DABT: exc_mode = MODE_ABT;
      EXC_IRQ:           exc_mode = MODE_IRQ;
      EXC_FIQ:           exc_mode = MODE_FIQ;
      default:           exc_mode = MODE_UND;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] exc_offset(input logic [KIND_W-1:0] kind);
    case (kind)
      EXC_UND:  exc_offset = VEC_UND;
      EXC_SWI:  exc_offset = VEC_SWI;
      EXC_PABT: exc_offset = VEC_PABT;
      EXC_DABT: exc_offset = VEC_DABT;
      EXC_IRQ:  exc_offset = VEC_IRQ;
      EXC_FIQ:  exc_offset = VEC_FIQ;
      default:  exc_offset = VEC_UND;
    endcase
  endfunction

endpackage

// File: rtl/regbank_map.sv
// Logical register number to physical bank index for a given processor mode.
module regbank_map
  import regbank_pkg::*;
(
  input  logic [MODE_W-1:0] mode_i,
  input  logic [LREG_W-1:0] lreg_i,
  output logic [IDX_W-1:0]  idx_c
);

  logic sp_lr;
  logic fiq_hi;

  assign sp_lr  = (lreg_i == 4'd13) || (lreg_i == 4'd14);
  assign fiq_hi = (lreg_i >= 4'd8) && (lreg_i != 4'd15);

  always_comb begin
    idx_c = IDX_W'(lreg_i);
    case (mode_i)
      MODE_USR, MODE_SYS: idx_c = IDX_W'(lreg_i);
      MODE_FIQ: if (fiq_hi) idx_c = IDX_FIQ_R8  + IDX_W'(lreg_i - 4'd8);
      MODE_SVC: if (sp_lr)  idx_c = IDX_SVC_R13 + IDX_W'(lreg_i - 4'd13);
      MODE_ABT: if (sp_lr)  idx_c = IDX_ABT_R13 + IDX_W'(lreg_i - 4'd13);
      MODE_IRQ: if (sp_lr)  idx_c = IDX_IRQ_R13 + IDX_W'(lreg_i - 4'd13);
      MODE_UND: if (sp_lr)  idx_c = IDX_UND_R13 + IDX_W'(lreg_i - 4'd13);
      default:  idx_c = IDX_W'(lreg_i);
    endcase
  end

endmodule

// File: rtl/regbank_ctrl.sv
// Register-bank front end: mode-aware index mapping, writeback port sharing and
// the exception-entry sequence (SPSR save, banked LR, CPSR update, vector load).
module regbank_ctrl
  import regbank_pkg::*;
#(
  parameter logic [DATA_W-1:0] VECTOR_BASE = 32'h0000_0000,
  parameter logic [MODE_W-1:0] RESET_MODE  = 5'b10011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LREG_W-1:0] rd1_lreg,
  input  logic [LREG_W-1:0] rd2_lreg,
  output logic              rd_stall,
  output logic [IDX_W-1:0]  rb_addr1,
  output logic [IDX_W-1:0]  rb_addr2,
  input  logic [DATA_W-1:0] rb_rd1_data,
  input  logic              wb_valid,
  input  logic [LREG_W-1:0] wb_lreg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              exc_valid,
  input  logic [KIND_W-1:0] exc_kind,
  input  logic [DATA_W-1:0] exc_ret,
  output logic              exc_ready,
  output logic              exc_done,
  output logic              rb_w,
  output logic [DATA_W-1:0] rb_write,
  output logic              rb_pc_w,
  output logic [DATA_W-1:0] rb_pc_write,
  output logic              rb_cpsr_w,
  output logic [DATA_W-1:0] rb_cpsr_write,
  output logic [DATA_W-1:0] rb_cpsr_mask,
  output logic [MODE_W-1:0] cur_mode
);

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   cur_mode_q, cur_mode_d;
  logic [MODE_W-1:0]   tgt_mode_q, tgt_mode_d;
  logic [DATA_W-1:0]   vector_q, vector_d;
  logic [DATA_W-1:0]   ret_q, ret_d;
  logic                shadow_f_q, shadow_f_d;

  logic                idle;
  logic [MODE_W-1:0]   wl_mode;
  logic [LREG_W-1:0]   wl_lreg;
  logic [IDX_W-1:0]    rd1_idx, rd2_idx, wl_idx;
  logic                new_f;

  // Third mapper serves writeback in IDLE and the banked LR during the sequence.
  assign idle     = (state_q == ST_IDLE);
  assign wl_mode  = idle ? cur_mode_q : tgt_mode_q;
  assign wl_lreg  = idle ? wb_lreg : 4'd14;
  assign new_f    = (tgt_mode_q == MODE_FIQ) | shadow_f_q;
  assign cur_mode = cur_mode_q;

  regbank_map u_map_rd1 (.mode_i(cur_mode_q), .lreg_i(rd1_lreg), .idx_c(rd1_idx));
  regbank_map u_map_rd2 (.mode_i(cur_mode_q), .lreg_i(rd2_lreg), .idx_c(rd2_idx));
  regbank_map u_map_wl  (.mode_i(wl_mode),    .lreg_i(wl_lreg),  .idx_c(wl_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_mode_q <= RESET_MODE;
      tgt_mode_q <= '0;
      vector_q   <= '0;
      ret_q      <= '0;
      shadow_f_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      tgt_mode_q <= tgt_mode_d;
      vector_q   <= vector_d;
      ret_q      <= ret_d;
      shadow_f_q <= shadow_f_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_mode_d    = cur_mode_q;
    tgt_mode_d    = tgt_mode_q;
    vector_d      = vector_q;
    ret_d         = ret_q;
    shadow_f_d    = shadow_f_q;
    rd_stall      = 1'b0;
    wb_ready      = 1'b0;
    exc_ready     = 1'b0;
    exc_done      = 1'b0;
    rb_addr1      = '0;
    rb_addr2      = '0;
    rb_w          = 1'b0;
    rb_write      = '0;
    rb_pc_w       = 1'b0;
    rb_pc_write   = '0;
    rb_cpsr_w     = 1'b0;
    rb_cpsr_write = '0;
    rb_cpsr_mask  = '0;

    // While rst is high every output shows its reset value.
    if (rst) begin
      exc_ready = 1'b1;
    end else begin
      rb_addr2 = rd2_idx;
      case (state_q)
        ST_IDLE: begin
          exc_ready = 1'b1;
          wb_ready  = 1'b1;
          rb_addr1  = rd1_idx;
          if (wb_valid) begin
            rb_addr1 = wl_idx;
            if (wb_lreg == 4'd15) begin
              rb_pc_w     = 1'b1;
              rb_pc_write = wb_data;
            end else begin
              rb_w     = 1'b1;
              rb_write = wb_data;
            end
          end
          if (exc_valid) begin
            tgt_mode_d = exc_mode(exc_kind);
            vector_d   = VECTOR_BASE + exc_offset(exc_kind);
            ret_d      = exc_ret;
            state_d    = ST_RD_CPSR;
          end
        end
        ST_RD_CPSR: begin
          rd_stall = 1'b1;
          rb_addr1 = IDX_CPSR;
          state_d  = ST_WR_SPSR;
        end
        ST_WR_SPSR: begin
          rd_stall   = 1'b1;
          rb_w       = 1'b1;
          rb_addr1   = spsr_idx(tgt_mode_q);
          rb_write   = rb_rd1_data;
          shadow_f_d = rb_rd1_data[6];
          state_d    = ST_WR_LR;
        end
        ST_WR_LR: begin
          rd_stall = 1'b1;
          rb_w     = 1'b1;
          rb_addr1 = wl_idx;
          rb_write = ret_q;
          state_d  = ST_WR_CPSR;
        end
        ST_WR_CPSR: begin
          rd_stall      = 1'b1;
          rb_addr1      = IDX_CPSR;
          rb_cpsr_w     = 1'b1;
          rb_cpsr_mask  = CPSR_CTRL_MASK;
          rb_cpsr_write = {24'b0, 1'b1, new_f, 1'b0, tgt_mode_q};
          cur_mode_d    = tgt_mode_q;
          state_d       = ST_WR_PC;
        end
        ST_WR_PC: begin
          rd_stall    = 1'b1;
          rb_addr1    = IDX_PC;
          rb_pc_w     = 1'b1;
          rb_pc_write = vector_q;
          exc_done    = 1'b1;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_ctrl.sv
// Scoreboard bench: a mode/CPSR reference model predicts bank writes and handshakes
// for directed exception scenarios followed by randomized traffic.
module tb_regbank_ctrl;

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;
  localparam int K_GEN  = 0;
  localparam int K_PC   = 1;
  localparam int K_CPSR = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic        done;
  } ev_t;

  ev_t sbq[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd1_lreg, rd2_lreg, wb_lreg;
  logic        rd_stall, wb_valid, wb_ready, exc_valid, exc_ready, exc_done;
  logic [5:0]  rb_addr1, rb_addr2;
  logic [31:0] rb_rd1_data, wb_data, exc_ret;
  logic [2:0]  exc_kind;
  logic        rb_w, rb_pc_w, rb_cpsr_w;
  logic [31:0] rb_write, rb_pc_write, rb_cpsr_write, rb_cpsr_mask;
  logic [4:0]  cur_mode;

  logic        u_stall, u_wb_ready, u_exc_ready, u_done, u_w, u_pc_w, u_cpsr_w;
  logic [5:0]  u_addr1, u_addr2;
  logic [31:0] u_write, u_pc_write, u_cpsr_write, u_cpsr_mask;
  logic [4:0]  u_mode;

  always #5 clk = ~clk;

  regbank_ctrl u_dut (
    .clk(clk), .rst(rst), .rd1_lreg(rd1_lreg), .rd2_lreg(rd2_lreg), .rd_stall(rd_stall),
    .rb_addr1(rb_addr1), .rb_addr2(rb_addr2), .rb_rd1_data(rb_rd1_data),
    .wb_valid(wb_valid), .wb_lreg(wb_lreg), .wb_data(wb_data), .wb_ready(wb_ready),
    .exc_valid(exc_valid), .exc_kind(exc_kind), .exc_ret(exc_ret), .exc_ready(exc_ready),
    .exc_done(exc_done), .rb_w(rb_w), .rb_write(rb_write), .rb_pc_w(rb_pc_w),
    .rb_pc_write(rb_pc_write), .rb_cpsr_w(rb_cpsr_w), .rb_cpsr_write(rb_cpsr_write),
    .rb_cpsr_mask(rb_cpsr_mask), .cur_mode(cur_mode)
  );

  // Second instance reset into USR, used only for the flat mapping.
  regbank_ctrl #(.RESET_MODE(5'b10000)) u_usr (
    .clk(clk), .rst(rst), .rd1_lreg(rd1_lreg), .rd2_lreg(rd2_lreg), .rd_stall(u_stall),
    .rb_addr1(u_addr1), .rb_addr2(u_addr2), .rb_rd1_data(32'h0),
    .wb_valid(1'b0), .wb_lreg(4'h0), .wb_data(32'h0), .wb_ready(u_wb_ready),
    .exc_valid(1'b0), .exc_kind(3'h0), .exc_ret(32'h0), .exc_ready(u_exc_ready),
    .exc_done(u_done), .rb_w(u_w), .rb_write(u_write), .rb_pc_w(u_pc_w),
    .rb_pc_write(u_pc_write), .rb_cpsr_w(u_cpsr_w), .rb_cpsr_write(u_cpsr_write),
    .rb_cpsr_mask(u_cpsr_mask), .cur_mode(u_mode)
  );

  // Environment bank: registered read on port 1, applies whatever the DUT writes.
  logic [31:0] bank [0:36];
  int env_a1;
  always @(posedge clk) begin
    env_a1 = int'(rb_addr1);
    if (rst) begin
      for (int i = 0; i < 37; i++) bank[i] <= 32'h0;
      bank[31]    <= 32'h0000_0010;
      rb_rd1_data <= 32'h0;
    end else begin
      rb_rd1_data <= (env_a1 < 37) ? bank[env_a1] : 32'h0;
      if (rb_w && env_a1 < 37) bank[env_a1] <= rb_write;
      if (rb_pc_w) bank[15] <= rb_pc_write;
      if (rb_cpsr_w) bank[31] <= (bank[31] & ~rb_cpsr_mask) | (rb_cpsr_write & rb_cpsr_mask);
    end
  end

  function automatic logic [5:0] ref_map(input logic [4:0] m, input logic [3:0] r);
    int ri;
    ri = int'(r);
    case (m)
      M_FIQ: if (ri >= 8 && ri <= 14) return 6'(16 + ri - 8);
      M_SVC: if (ri == 13 || ri == 14) return 6'(23 + ri - 13);
      M_ABT: if (ri == 13 || ri == 14) return 6'(25 + ri - 13);
      M_IRQ: if (ri == 13 || ri == 14) return 6'(27 + ri - 13);
      M_UND: if (ri == 13 || ri == 14) return 6'(29 + ri - 13);
      default: ;
    endcase
    return 6'(ri);
  endfunction

  function automatic logic [5:0] ref_spsr(input logic [4:0] m);
    case (m)
      M_FIQ:   return 6'd32;
      M_SVC:   return 6'd33;
      M_ABT:   return 6'd34;
      M_IRQ:   return 6'd35;
      default: return 6'd36;
    endcase
  endfunction

  function automatic logic [4:0] ref_tmode(input logic [2:0] k);
    case (k)
      3'd1:       return M_SVC;
      3'd2, 3'd3: return M_ABT;
      3'd4:       return M_IRQ;
      3'd5:       return M_FIQ;
      default:    return M_UND;
    endcase
  endfunction

  function automatic logic [31:0] ref_vec(input logic [2:0] k);
    case (k)
      3'd1:    return 32'h08;
      3'd2:    return 32'h0C;
      3'd3:    return 32'h10;
      3'd4:    return 32'h18;
      3'd5:    return 32'h1C;
      default: return 32'h04;
    endcase
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: phase counts cycles since acceptance (0 = idle).
  int          cyc_now = 0;
  int          phase = 0;
  logic [4:0]  m_mode = M_SVC;
  logic [31:0] ref_cpsr = 32'h0000_0010;
  logic [31:0] pend_cpsr;
  logic [4:0]  pend_mode;

  logic        exp_on = 1'b0;
  logic        e_rst, e_exc_ready, e_wb_ready, e_stall, e_a1_chk;
  logic [5:0]  e_a1, e_a2;
  logic [4:0]  e_mode;

  task automatic cycle(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic wv, input logic [3:0] wl, input logic [31:0] wd,
                       input logic ev, input logic [2:0] k, input logic [31:0] rt);
    logic [4:0] tgt;
    @(posedge clk);
    #1;
    cyc_now++;
    rst = r; rd1_lreg = a; rd2_lreg = b;
    wb_valid = wv; wb_lreg = wl; wb_data = wd;
    exc_valid = ev; exc_kind = k; exc_ret = rt;

    e_rst = r; e_mode = m_mode; e_a1_chk = 1'b0;
    if (r) begin
      e_exc_ready = 1'b1; e_wb_ready = 1'b0; e_stall = 1'b0;
      e_a1_chk = 1'b1; e_a1 = 6'd0; e_a2 = 6'd0;
    end else if (phase == 0) begin
      e_exc_ready = 1'b1; e_wb_ready = 1'b1; e_stall = 1'b0;
      e_a2 = ref_map(m_mode, b);
      e_a1_chk = 1'b1;
      e_a1 = wv ? ref_map(m_mode, wl) : ref_map(m_mode, a);
      if (wv) sbq.push_back('{cyc_now, (wl == 4'd15) ? K_PC : K_GEN, ref_map(m_mode, wl), wd, 32'h0, 1'b0});
    end else begin
      e_exc_ready = 1'b0; e_wb_ready = 1'b0; e_stall = 1'b1;
      e_a2 = ref_map(m_mode, b);
      if (phase == 1) begin e_a1_chk = 1'b1; e_a1 = 6'd31; end
    end
    exp_on = 1'b1;

    if (r) begin
      phase = 0; m_mode = M_SVC; ref_cpsr = 32'h0000_0010;
      for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].cyc >= cyc_now) sbq.delete(i);
    end else if (phase == 0) begin
      if (ev) begin
        tgt = ref_tmode(k);
        pend_mode = tgt;
        pend_cpsr = {ref_cpsr[31:8], 1'b1, (tgt == M_FIQ) | ref_cpsr[6], 1'b0, tgt};
        sbq.push_back('{cyc_now + 2, K_GEN, ref_spsr(tgt), ref_cpsr, 32'h0, 1'b0});
        sbq.push_back('{cyc_now + 3, K_GEN, ref_map(tgt, 4'd14), rt, 32'h0, 1'b0});
        sbq.push_back('{cyc_now + 4, K_CPSR, 6'd31, {24'h0, pend_cpsr[7:0]}, 32'hFF, 1'b0});
        sbq.push_back('{cyc_now + 5, K_PC, 6'd15, ref_vec(k), 32'h0, 1'b1});
        phase = 1;
      end
    end else if (phase == 4) begin
      ref_cpsr = pend_cpsr; m_mode = pend_mode; phase = 5;
    end else if (phase == 5) begin
      phase = 0;
    end else begin
      phase++;
    end
  endtask

  task automatic idle(input logic [3:0] a, input logic [3:0] b);
    cycle(1'b0, a, b, 1'b0, 4'h0, 32'h0, 1'b0, 3'h0, 32'h0);
  endtask

  // Monitor: handshakes every cycle; pops the scoreboard whenever the DUT writes.
  ev_t m_ev;
  int  m_kind;
  always @(negedge clk) begin
    if (exp_on) begin
      chk("exc_ready", cyc_now, 32'(exc_ready), 32'(e_exc_ready));
      chk("wb_ready", cyc_now, 32'(wb_ready), 32'(e_wb_ready));
      chk("rd_stall", cyc_now, 32'(rd_stall), 32'(e_stall));
      chk("cur_mode", cyc_now, 32'(cur_mode), 32'(e_mode));
      chk("rb_addr2", cyc_now, 32'(rb_addr2), 32'(e_a2));
      if (e_a1_chk) chk("rb_addr1", cyc_now, 32'(rb_addr1), 32'(e_a1));
      if (!e_rst) begin
        chk("usr_addr1", cyc_now, 32'(u_addr1), 32'(ref_map(M_USR, rd1_lreg)));
        chk("usr_addr2", cyc_now, 32'(u_addr2), 32'(ref_map(M_USR, rd2_lreg)));
      end
      while (sbq.size() > 0 && sbq[0].cyc < cyc_now) begin
        m_ev = sbq.pop_front();
        chk("missed_write_cycle", cyc_now, 32'(cyc_now), 32'(m_ev.cyc));
      end
      if (rb_w || rb_pc_w || rb_cpsr_w || exc_done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_write", cyc_now, {rb_w, rb_pc_w, rb_cpsr_w, exc_done}, 32'h0);
        end else begin
          m_ev   = sbq.pop_front();
          m_kind = rb_cpsr_w ? K_CPSR : (rb_pc_w ? K_PC : K_GEN);
          chk("wr_cycle", cyc_now, 32'(cyc_now), 32'(m_ev.cyc));
          chk("wr_onehot", cyc_now, 32'($countones({rb_w, rb_pc_w, rb_cpsr_w})), 32'd1);
          chk("wr_kind", cyc_now, 32'(m_kind), 32'(m_ev.kind));
          chk("exc_done", cyc_now, 32'(exc_done), 32'(m_ev.done));
          case (m_ev.kind)
            K_GEN: begin
              chk("wr_addr", cyc_now, 32'(rb_addr1), 32'(m_ev.addr));
              chk("wr_data", cyc_now, rb_write, m_ev.data);
            end
            K_PC: chk("pc_data", cyc_now, rb_pc_write, m_ev.data);
            default: begin
              chk("cpsr_data", cyc_now, rb_cpsr_write, m_ev.data);
              chk("cpsr_mask", cyc_now, rb_cpsr_mask, m_ev.mask);
            end
          endcase
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rd1_lreg = 4'h0; rd2_lreg = 4'h0; wb_valid = 1'b0; wb_lreg = 4'h0;
    wb_data = 32'h0; exc_valid = 1'b0; exc_kind = 3'h0; exc_ret = 32'h0;

    cycle(1'b1, 4'd13, 4'd14, 1'b0, 4'h0, 32'h0, 1'b0, 3'h0, 32'h0);
    cycle(1'b1, 4'd13, 4'd14, 1'b0, 4'h0, 32'h0, 1'b0, 3'h0, 32'h0);
    idle(4'd13, 4'd14);
    idle(4'd13, 4'd5);

    // IRQ entry from CPSR 0x10 with return address 0x100.
    cycle(1'b0, 4'd1, 4'd2, 1'b0, 4'h0, 32'h0, 1'b1, 3'd4, 32'h0000_0100);
    repeat (5) idle(4'd0, 4'd1);
    idle(4'd13, 4'd14);

    // Writeback and exception in the same idle cycle.
    cycle(1'b0, 4'd1, 4'd2, 1'b1, 4'd3, 32'h0000_00AA, 1'b1, 3'd3, 32'h0000_2000);
    repeat (5) idle(4'd4, 4'd5);

    // FIQ entry with a second request arriving during the LR write.
    cycle(1'b0, 4'd1, 4'd2, 1'b0, 4'h0, 32'h0, 1'b1, 3'd5, 32'h0000_3000);
    idle(4'd0, 4'd0);
    idle(4'd0, 4'd0);
    cycle(1'b0, 4'd1, 4'd2, 1'b0, 4'h0, 32'h0, 1'b1, 3'd1, 32'h0000_4000);
    idle(4'd0, 4'd0);
    idle(4'd0, 4'd0);
    idle(4'd8, 4'd14);
    cycle(1'b0, 4'd9, 4'd13, 1'b1, 4'd15, 32'h0000_0444, 1'b0, 3'h0, 32'h0);

    // Reset while the SPSR write is on the bus.
    cycle(1'b0, 4'd1, 4'd2, 1'b0, 4'h0, 32'h0, 1'b1, 3'd7, 32'h0000_5000);
    idle(4'd0, 4'd0);
    cycle(1'b1, 4'd0, 4'd0, 1'b0, 4'h0, 32'h0, 1'b0, 3'h0, 32'h0);
    repeat (6) idle(4'd13, 4'd14);

    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) == 0), 4'($urandom), 4'($urandom),
            1'($urandom), 4'($urandom), $urandom,
            ($urandom_range(0, 7) == 0), 3'($urandom), $urandom);
    end

    repeat (8) idle(4'd0, 4'd0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc_now, 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
